eth_tx_arb: RTL

//  Round-robin, frame-granular arbiter sharing the single Ethernet TX byte port (o_wdata/o_wvalid/i_wready)

---
 rtl/eth_tx_arb_if.sv | 33 +++
 rtl/eth_tx_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb_if.sv
// Bundle of the source-side and MAC-side signals of the Ethernet TX arbiter.
//   i_src_req/valid/last/data : from the N_SRC packet sources (byte k on data[8k+7:8k])
//   o_src_ready/o_src_grant   : back to the sources (grant is one-hot owner, 0 when none)
//   o_wdata/o_wvalid/o_wlast  : registered TX byte towards the MAC, i_wready from the MAC
//   o_trunc                   : one-cycle pulse when a frame is cut at MAX_LEN
//   o_busy                    : arbiter is not idle
// modport master: the arbiter itself; modport slave: sources plus MAC.
interface eth_tx_arb_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0]   i_src_req;
  logic [8*N_SRC-1:0] i_src_data;
  logic [N_SRC-1:0]   i_src_valid;
  logic [N_SRC-1:0]   i_src_last;
  logic [N_SRC-1:0]   o_src_ready;
  logic [N_SRC-1:0]   o_src_grant;
  logic [7:0]         o_wdata;
  logic               o_wvalid;
  logic               o_wlast;
  logic               i_wready;
  logic               o_trunc;
  logic               o_busy;

  modport master (
    input  i_src_req, i_src_data, i_src_valid, i_src_last, i_wready,
    output o_src_ready, o_src_grant, o_wdata, o_wvalid, o_wlast, o_trunc, o_busy
  );

  modport slave (
    output i_src_req, i_src_data, i_src_valid, i_src_last, i_wready,
    input  o_src_ready, o_src_grant, o_wdata, o_wvalid, o_wlast, o_trunc, o_busy
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Round-robin, frame-granular arbiter sharing the Ethernet TX byte port between
// N_SRC packet sources. Grant is held for a whole frame, an idle gap of IFG_CYC
// cycles follows every frame, and frames longer than MAX_LEN are cut (o_trunc)
// with the remainder drained from the source and discarded.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   bus      eth_tx_arb_if.master (source handshake, grant, TX byte port, status)
module eth_tx_arb #(
  parameter int N_SRC   = 4,
  parameter int MAX_LEN = 1500,
  parameter int IFG_CYC = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  eth_tx_arb_if.master  bus
);

  localparam int unsigned NS = N_SRC;
  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int FW = $clog2(IFG_CYC + 1);

  typedef enum logic [2:0] {IDLE, XFER, FLUSH, DRAIN, GAP} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  gidx_q, gidx_d;
  logic [GW-1:0]  rr_q, rr_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]  gap_q, gap_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           wvalid_q, wvalid_d;
  logic           wlast_q, wlast_d;
  logic           trunc_q, trunc_d;

  logic           out_free;
  logic           take_en;
  logic           acc;
  logic           sel_last;
  logic [7:0]     sel_data;
  logic           at_max;
  logic           found;
  logic [GW-1:0]  pick;
  logic [GW-1:0]  kk;

  assign out_free = !wvalid_q || bus.i_wready;
  // FLUSH discards bytes, so it accepts regardless of the output register.
  assign take_en  = ((state_q == XFER) && out_free) || (state_q == FLUSH);
  assign acc      = take_en && bus.i_src_valid[gidx_q];
  assign sel_last = bus.i_src_last[gidx_q];
  assign sel_data = bus.i_src_data[{gidx_q, 3'b000} +: 8];
  assign at_max   = (cnt_q == CW'(MAX_LEN - 1));

  // First requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    kk    = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      kk = GW'((32'(rr_q) + i) % NS);
      if (!found && bus.i_src_req[kk]) begin
        found = 1'b1;
        pick  = kk;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    wlast_d  = wlast_q;
    trunc_d  = 1'b0;

    if (wvalid_q && bus.i_wready) begin
      wdata_d  = '0;
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          cnt_d         = '0;
          state_d       = XFER;
        end
      end
      XFER: begin
        if (acc) begin
          wdata_d  = sel_data;
          wvalid_d = 1'b1;
          wlast_d  = sel_last || at_max;
          cnt_d    = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = DRAIN;
          end else if (at_max) begin
            trunc_d = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (acc && sel_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as the final byte is consumed so the gap counts from the
        // first cycle the port is empty.
        if (out_free) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == FW'(IFG_CYC - 1)) begin
          grant_d = '0;
          rr_d    = (gidx_q == GW'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wlast_q  <= wlast_d;
      trunc_q  <= trunc_d;
    end
  end

  assign bus.o_src_ready = take_en ? grant_q : '0;
  assign bus.o_src_grant = grant_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_wvalid    = wvalid_q;
  assign bus.o_wlast     = wlast_q;
  assign bus.o_trunc     = trunc_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule
